msk_rx_acq_ctrl: RTL and testbench

Acquisition sequencer for the MSK receive chain. It sits beside the timing-recovery loop (gardner TED, PI filter, phase accumulator) and the carrier-recovery loop (coarse CFO estimator, derotator, phase detector, CFO loop filter, NCO). It steps the receiver through timing settle, coarse CFO estimation, NCO preload and fine carrier tracking. It declares lock from phase-detector error statistics and restarts acquisition on loss of lock or timeout.

---
 rtl/msk_rx_pkg.sv | 22 ++
 rtl/acq_lock_det.sv | 65 ++++++
 rtl/msk_rx_acq_ctrl.sv | 135 +++++++++++++
 tb/tb_msk_rx_acq_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_rx_pkg.sv
// Shared types and helpers for the MSK receive acquisition sequencer.
// The acquisition state encodings double as the debug state_o value.
package msk_rx_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StTimAcq  = 3'd1,
    StCfoEst  = 3'd2,
    StNcoLoad = 3'd3,
    StTrack   = 3'd4,
    StLocked  = 3'd5
  } acq_state_t;

  // Absolute value one bit wider than the input, so the most negative value needs no wrap.
  // Callers sign-extend their EW-bit error into x.
  function automatic logic [64:0] abs_ext(input logic signed [63:0] x);
    logic signed [64:0] xe;
    xe = 65'(x);
    return xe[64] ? $unsigned(-xe) : $unsigned(xe);
  endfunction

endpackage

// File: rtl/acq_lock_det.sv
// Phase-error lock detector: threshold compare on |phase_err| plus saturating
// good/bad run counters. The top decides state; this block only reports hits.
module acq_lock_det
  import msk_rx_pkg::*;
#(
  parameter int unsigned EW          = 24,
  parameter int unsigned LOCK_THR    = 2 ** (EW - 4),
  parameter int unsigned LOCK_SYMS   = 128,
  parameter int unsigned UNLOCK_SYMS = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          err_val,
  input  logic [EW-1:0] phase_err,
  input  logic          clear,
  input  logic          locked,
  output logic          lock_hit,
  output logic          unlock_hit
);

  localparam int unsigned GoodW = $clog2(LOCK_SYMS) + 1;
  localparam int unsigned BadW  = $clog2(UNLOCK_SYMS) + 1;

  logic [GoodW-1:0] good_cnt_q, good_cnt_d;
  logic [BadW-1:0]  bad_cnt_q, bad_cnt_d;
  logic [64:0]      err_abs;
  logic             err_good;

  always_comb begin
    err_abs    = abs_ext(64'($signed(phase_err)));
    err_good   = err_abs < 65'(LOCK_THR);
    lock_hit   = err_val && !locked && err_good && (good_cnt_q == GoodW'(LOCK_SYMS - 1));
    unlock_hit = err_val && locked && !err_good && (bad_cnt_q == BadW'(UNLOCK_SYMS - 1));
  end

  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (clear) begin
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else if (locked) begin
      good_cnt_d = '0;
      if (err_val) begin
        bad_cnt_d = err_good ? '0 : ((bad_cnt_q == '1) ? bad_cnt_q : bad_cnt_q + 1'b1);
      end
    end else begin
      bad_cnt_d = '0;
      if (err_val) begin
        good_cnt_d = !err_good ? '0 : ((good_cnt_q == '1) ? good_cnt_q : good_cnt_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

endmodule

// File: rtl/msk_rx_acq_ctrl.sv
// MSK receive acquisition sequencer: timing settle, coarse CFO, NCO preload,
// fine tracking and lock supervision. Outputs are Moore-decoded from state.
module msk_rx_acq_ctrl
  import msk_rx_pkg::*;
#(
  parameter int unsigned PW          = 32,
  parameter int unsigned EW          = 24,
  parameter int unsigned TACQ_SYMS   = 512,
  parameter int unsigned CFO_TIMEOUT = 4096,
  parameter int unsigned LOCK_THR    = 2 ** (EW - 4),
  parameter int unsigned LOCK_SYMS   = 128,
  parameter int unsigned UNLOCK_SYMS = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable_i,
  input  logic          sym_val_i,
  input  logic          cfo_done_i,
  input  logic [PW-1:0] cfo_word_i,
  input  logic          err_val_i,
  input  logic [EW-1:0] phase_err_i,
  output logic          cfo_en_o,
  output logic          nco_load_o,
  output logic [PW-1:0] nco_word_o,
  output logic          track_en_o,
  output logic          locked_o,
  output logic          timeout_o,
  output logic [2:0]    state_o
);

  localparam int unsigned SymMax = (TACQ_SYMS > CFO_TIMEOUT) ? TACQ_SYMS : CFO_TIMEOUT;
  localparam int unsigned SymW   = $clog2(SymMax) + 1;

  acq_state_t      state_q, state_d;
  logic [SymW-1:0] sym_cnt_q, sym_cnt_d;
  logic [PW-1:0]   nco_word_q, nco_word_d;
  logic            timeout_q, timeout_d;
  logic            tacq_hit, cfo_to_hit, in_track;
  logic            det_err_val, det_clear, lock_hit, unlock_hit;

  always_comb begin
    in_track    = (state_q == StTrack) || (state_q == StLocked);
    tacq_hit    = sym_val_i && (sym_cnt_q == SymW'(TACQ_SYMS - 1));
    cfo_to_hit  = sym_val_i && (sym_cnt_q == SymW'(CFO_TIMEOUT - 1));
    det_err_val = err_val_i && enable_i && in_track;
    det_clear   = !in_track || !enable_i;
  end

  acq_lock_det #(
    .EW          (EW),
    .LOCK_THR    (LOCK_THR),
    .LOCK_SYMS   (LOCK_SYMS),
    .UNLOCK_SYMS (UNLOCK_SYMS)
  ) u_lock_det (
    .clk        (clk),
    .reset_n    (reset_n),
    .err_val    (det_err_val),
    .phase_err  (phase_err_i),
    .clear      (det_clear),
    .locked     (state_q == StLocked),
    .lock_hit   (lock_hit),
    .unlock_hit (unlock_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StTimAcq;
        StTimAcq:  if (tacq_hit) state_d = StCfoEst;
        // A done pulse beats a simultaneous timeout.
        StCfoEst: begin
          if (cfo_done_i) begin
            state_d = StNcoLoad;
          end else if (cfo_to_hit) begin
            state_d = StTimAcq;
          end
        end
        StNcoLoad: state_d = StTrack;
        StTrack:   if (lock_hit) state_d = StLocked;
        StLocked:  if (unlock_hit) state_d = StTimAcq;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Symbol counter restarts on every state change and only runs while settling or estimating.
  always_comb begin
    sym_cnt_d = '0;
    if (enable_i && (state_d == state_q) && ((state_q == StTimAcq) || (state_q == StCfoEst))) begin
      sym_cnt_d = !sym_val_i ? sym_cnt_q :
                  ((sym_cnt_q == '1) ? sym_cnt_q : sym_cnt_q + 1'b1);
    end
    nco_word_d = (enable_i && (state_q == StCfoEst) && cfo_done_i) ? cfo_word_i : nco_word_q;
    timeout_d  = timeout_q;
    if (!enable_i) begin
      timeout_d = 1'b0;
    end else if ((state_q == StCfoEst) && (state_d == StTimAcq)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_cnt_q  <= '0;
      nco_word_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      sym_cnt_q  <= sym_cnt_d;
      nco_word_q <= nco_word_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    cfo_en_o   = (state_q == StCfoEst);
    nco_load_o = (state_q == StNcoLoad);
    track_en_o = in_track;
    locked_o   = (state_q == StLocked);
    timeout_o  = timeout_q;
    nco_word_o = nco_word_q;
    state_o    = state_q;
  end

endmodule

// File: tb/tb_msk_rx_acq_ctrl.sv
// Scoreboard bench for msk_rx_acq_ctrl: expectations are queued as stimulus is
// driven and compared against DUT outputs on the following falling edge.
module tb_msk_rx_acq_ctrl;

  localparam int unsigned PW   = 32;
  localparam int unsigned EW   = 24;
  localparam int unsigned Thr  = 2 ** (EW - 4);
  localparam int unsigned Tacq = 8;
  localparam int unsigned CfoTo = 16;

  localparam int SelState = 0, SelCfoEn = 1, SelLoad = 2, SelWord = 3;
  localparam int SelTrack = 4, SelLocked = 5, SelTimeout = 6;

  logic          clk = 1'b0;
  logic          reset_n, enable, sym_val, cfo_done, err_val;
  logic [PW-1:0] cfo_word;
  logic [EW-1:0] phase_err;
  logic          cfo_en, nco_load, track_en, locked, timeout;
  logic [PW-1:0] nco_word;
  logic [2:0]    state;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   load_cnt = 0;

  always #5 clk = ~clk;

  msk_rx_acq_ctrl #(
    .PW          (PW),
    .EW          (EW),
    .TACQ_SYMS   (Tacq),
    .CFO_TIMEOUT (CfoTo),
    .LOCK_THR    (Thr),
    .LOCK_SYMS   (4),
    .UNLOCK_SYMS (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable_i    (enable),
    .sym_val_i   (sym_val),
    .cfo_done_i  (cfo_done),
    .cfo_word_i  (cfo_word),
    .err_val_i   (err_val),
    .phase_err_i (phase_err),
    .cfo_en_o    (cfo_en),
    .nco_load_o  (nco_load),
    .nco_word_o  (nco_word),
    .track_en_o  (track_en),
    .locked_o    (locked),
    .timeout_o   (timeout),
    .state_o     (state)
  );

  always @(negedge clk) if (nco_load) load_cnt++;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs(input int sel);
    case (sel)
      SelState:   return 64'(state);
      SelCfoEn:   return 64'(cfo_en);
      SelLoad:    return 64'(nco_load);
      SelWord:    return 64'(nco_word);
      SelTrack:   return 64'(track_en);
      SelLocked:  return 64'(locked);
      default:    return 64'(timeout);
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic push_all_zero(input string tag);
    for (int s = SelState; s <= SelTimeout; s++) push(tag, s, 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    drain();
  endtask

  // Strobe one symbol, compare, then idle out the rest of the 20-cycle symbol period.
  task automatic sym_pulse(input logic with_done, input logic [PW-1:0] word);
    sym_val  = 1'b1;
    cfo_done = with_done;
    cfo_word = word;
    step();
    sym_val  = 1'b0;
    cfo_done = 1'b0;
    if (!with_done) for (int i = 0; i < 19; i++) step();
  endtask

  task automatic send_err(input logic [EW-1:0] v);
    phase_err = v;
    err_val   = 1'b1;
    step();
    err_val   = 1'b0;
  endtask

  task automatic acquire(input logic [PW-1:0] word);
    enable = 1'b1;
    step();
    for (int i = 0; i < Tacq; i++) sym_pulse(1'b0, '0);
    push("acq_load", SelState, 64'd3);
    cfo_done = 1'b1;
    cfo_word = word;
    step();
    cfo_done = 1'b0;
    push("acq_track", SelState, 64'd4);
    step();
  endtask

  initial begin
    logic [EW-1:0] good_seq [7];
    logic [EW-1:0] unl_seq [6];
    reset_n = 1'b0; enable = 1'b0; sym_val = 1'b0; cfo_done = 1'b0;
    err_val = 1'b0; cfo_word = '0; phase_err = '0;
    #12;
    push_all_zero("reset");
    drain();
    @(negedge clk);
    reset_n = 1'b1;

    // Nominal acquisition
    enable = 1'b1;
    push("en_rise", SelState, 64'd1);
    step();
    for (int i = 0; i < Tacq - 1; i++) begin
      push("tacq_hold", SelState, 64'd1);
      sym_pulse(1'b0, '0);
    end
    push("to_cfo", SelState, 64'd2);
    push("cfo_en", SelCfoEn, 64'd1);
    sym_pulse(1'b0, '0);
    for (int i = 0; i < 3; i++) sym_pulse(1'b0, '0);
    push("nco_state", SelState, 64'd3);
    push("nco_load", SelLoad, 64'd1);
    push("nco_word", SelWord, 64'h0001_2345);
    push("cfo_en_off", SelCfoEn, 64'd0);
    push("no_track_yet", SelTrack, 64'd0);
    cfo_done = 1'b1;
    cfo_word = 32'h0001_2345;
    step();
    cfo_done = 1'b0;
    cfo_word = '0;
    push("track_state", SelState, 64'd4);
    push("load_drop", SelLoad, 64'd0);
    push("track_en", SelTrack, 64'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      push("pre_lock", SelLocked, 64'd0);
      send_err(EW'(10));
    end
    push("lock", SelLocked, 64'd1);
    push("lock_state", SelState, 64'd5);
    send_err(EW'(10));
    step();
    check_eq("load_pulses", 64'(load_cnt), 64'd1);

    // Enable abort while locked
    enable = 1'b0;
    push("abort_state", SelState, 64'd0);
    push("abort_locked", SelLocked, 64'd0);
    push("abort_track", SelTrack, 64'd0);
    push("abort_word", SelWord, 64'h0001_2345);
    step();

    // Lock hysteresis with threshold boundaries
    acquire(32'h0000_ABCD);
    good_seq[0] = EW'(10);
    good_seq[1] = EW'(Thr - 1);
    good_seq[2] = EW'(10);
    good_seq[3] = EW'(Thr);
    good_seq[4] = EW'(-int'(Thr - 1));
    good_seq[5] = EW'(10);
    good_seq[6] = EW'(10);
    for (int i = 0; i < 7; i++) begin
      push("hyst_pre", SelLocked, 64'd0);
      send_err(good_seq[i]);
    end
    push("hyst_lock", SelLocked, 64'd1);
    send_err(EW'(5));
    unl_seq[0] = {1'b1, {(EW - 1){1'b0}}};
    unl_seq[1] = EW'(Thr);
    unl_seq[2] = EW'(-int'(Thr - 1));
    unl_seq[3] = EW'(Thr + 7);
    unl_seq[4] = EW'(-int'(Thr));
    for (int i = 0; i < 5; i++) begin
      push("hold_lock", SelLocked, 64'd1);
      send_err(unl_seq[i]);
    end
    push("unlock", SelLocked, 64'd0);
    push("unlock_track", SelTrack, 64'd0);
    push("unlock_state", SelState, 64'd1);
    push("unlock_word", SelWord, 64'h0000_ABCD);
    send_err(EW'(Thr));

    // Coarse timeout
    for (int i = 0; i < Tacq; i++) sym_pulse(1'b0, '0);
    for (int i = 0; i < CfoTo - 1; i++) sym_pulse(1'b0, '0);
    push("pre_to_state", SelState, 64'd2);
    drain();
    push("to_flag", SelTimeout, 64'd1);
    push("to_state", SelState, 64'd1);
    push("to_cfo_en", SelCfoEn, 64'd0);
    sym_pulse(1'b0, '0);
    enable = 1'b0;
    push("to_clear", SelTimeout, 64'd0);
    push("to_idle", SelState, 64'd0);
    step();

    // Done and timeout in the same cycle
    enable = 1'b1;
    step();
    for (int i = 0; i < Tacq; i++) sym_pulse(1'b0, '0);
    for (int i = 0; i < CfoTo - 1; i++) sym_pulse(1'b0, '0);
    push("tie_state", SelState, 64'd3);
    push("tie_timeout", SelTimeout, 64'd0);
    push("tie_word", SelWord, 64'h5555_AAAA);
    sym_pulse(1'b1, 32'h5555_AAAA);

    // Asynchronous reset during NCO_LOAD
    reset_n = 1'b0;
    #1;
    push_all_zero("async_rst");
    drain();
    @(negedge clk);
    reset_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
